// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address,
// and registers the fetched word into the IF/ID pipeline register.
// Branches resolve in ID with one delay slot, so a redirect never squashes the
// instruction fetched alongside it. A redirect that arrives while the stage is
// stalled is buffered and applied on the first unstalled cycle.
module fetch_stage #(
  parameter int unsigned           ADDR_WIDTH  = 64,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   br_taken,
  input  logic                   uncond_br,
  input  logic                   br_reg,
  input  logic [ADDR_WIDTH-1:0]  br_pc,
  input  logic [25:0]            br_addr26,
  input  logic [18:0]            cond_addr19,
  input  logic [ADDR_WIDTH-1:0]  reg_target,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic [INSTR_WIDTH-1:0] if_id_instr,
  output logic [ADDR_WIDTH-1:0]  if_id_pc,
  output logic [ADDR_WIDTH-1:0]  if_id_pc_plus4,
  output logic                   if_id_valid,
  output logic                   redirect_pending
);

  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  id_pc_q, id_pc_d;
  logic [ADDR_WIDTH-1:0]  id_pc4_q, id_pc4_d;
  logic                   valid_q, valid_d;
  logic                   pend_q, pend_d;
  logic [ADDR_WIDTH-1:0]  pend_target_q, pend_target_d;

  logic [ADDR_WIDTH-1:0]  off26;
  logic [ADDR_WIDTH-1:0]  off19;
  logic [ADDR_WIDTH-1:0]  pc_plus4;
  logic [ADDR_WIDTH-1:0]  br_target;

  // Word offsets are sign-extended and scaled to byte offsets.
  assign off26    = {{(ADDR_WIDTH-28){br_addr26[25]}}, br_addr26, 2'b00};
  assign off19    = {{(ADDR_WIDTH-21){cond_addr19[18]}}, cond_addr19, 2'b00};
  assign pc_plus4 = pc_q + ADDR_WIDTH'(4);

  // Branch target select: BR overrides the immediate forms.
  always_comb begin
    br_target = br_pc + off19;
    if (br_reg) begin
      br_target = reg_target;
    end else if (uncond_br) begin
      br_target = br_pc + off26;
    end
  end

  // Next-state: advance on a normal cycle, hold and buffer any redirect on a stall.
  always_comb begin
    pc_d          = pc_q;
    instr_d       = instr_q;
    id_pc_d       = id_pc_q;
    id_pc4_d      = id_pc4_q;
    valid_d       = valid_q;
    pend_d        = pend_q;
    pend_target_d = pend_target_q;
    if (stall) begin
      // Last redirect seen during a stall wins.
      if (br_taken) begin
        pend_d        = 1'b1;
        pend_target_d = br_target;
      end
    end else begin
      // The word fetched this cycle is the delay slot when br_taken is high; keep it.
      instr_d  = instr_in;
      id_pc_d  = pc_q;
      id_pc4_d = pc_plus4;
      valid_d  = 1'b1;
      pend_d   = 1'b0;
      if (br_taken) begin
        pc_d = br_target;
      end else if (pend_q) begin
        pc_d = pend_target_q;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      id_pc_q       <= '0;
      id_pc4_q      <= '0;
      valid_q       <= 1'b0;
      pend_q        <= 1'b0;
      pend_target_q <= '0;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      id_pc_q       <= id_pc_d;
      id_pc4_q      <= id_pc4_d;
      valid_q       <= valid_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pc               = pc_q;
  assign if_id_instr      = instr_q;
  assign if_id_pc         = id_pc_q;
  assign if_id_pc_plus4   = id_pc4_q;
  assign if_id_valid      = valid_q;
  assign redirect_pending = pend_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a driver applies directed then random
// stimulus and pushes the reference model's expected outputs; a monitor pops
// and compares them after every clock edge. Two instances run side by side,
// one with RESET_PC=0 and one with RESET_PC at the top of the address space.
module tb_fetch_stage;

  localparam logic [63:0] HI_RESET_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
    logic [63:0] ipc;
    logic [63:0] ip4;
    logic        v;
    logic        pend;
    logic [63:0] pt;
  } st_t;

  typedef struct packed {
    st_t lo;
    st_t hi;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        bt = 1'b0;
  logic        ub = 1'b0;
  logic        brg = 1'b0;
  logic [63:0] bpc = '0;
  logic [25:0] a26 = '0;
  logic [18:0] a19 = '0;
  logic [63:0] rtgt = '0;

  logic [31:0] instr_lo, instr_hi;
  logic [63:0] pc_lo, ipc_lo, ip4_lo, pc_hi, ipc_hi, ip4_hi;
  logic [31:0] iins_lo, iins_hi;
  logic        v_lo, pend_lo, v_hi, pend_hi;

  int checks = 0;
  int errors = 0;

  pair_t exp_q[$];
  st_t   m_lo = '0;
  st_t   m_hi = '0;

  // Instruction memory content: word k at byte address 4k for low addresses.
  function automatic logic [31:0] imem(input logic [63:0] a);
    return a[33:2] ^ a[63:32];
  endfunction

  assign instr_lo = imem(pc_lo);
  assign instr_hi = imem(pc_hi);

  fetch_stage #(.ADDR_WIDTH(64), .INSTR_WIDTH(32), .RESET_PC(64'h0)) u_dut (
    .clk(clk), .reset(rst), .stall(stall), .br_taken(bt), .uncond_br(ub), .br_reg(brg),
    .br_pc(bpc), .br_addr26(a26), .cond_addr19(a19), .reg_target(rtgt), .instr_in(instr_lo),
    .pc(pc_lo), .if_id_instr(iins_lo), .if_id_pc(ipc_lo), .if_id_pc_plus4(ip4_lo),
    .if_id_valid(v_lo), .redirect_pending(pend_lo)
  );

  fetch_stage #(.ADDR_WIDTH(64), .INSTR_WIDTH(32), .RESET_PC(HI_RESET_PC)) u_dut_hi (
    .clk(clk), .reset(rst), .stall(stall), .br_taken(bt), .uncond_br(ub), .br_reg(brg),
    .br_pc(bpc), .br_addr26(a26), .cond_addr19(a19), .reg_target(rtgt), .instr_in(instr_hi),
    .pc(pc_hi), .if_id_instr(iins_hi), .if_id_pc(ipc_hi), .if_id_pc_plus4(ip4_hi),
    .if_id_valid(v_hi), .redirect_pending(pend_hi)
  );

  initial forever #5 clk = ~clk;

  // Architectural model: state after the next clock edge given the current inputs.
  function automatic st_t step(input st_t s, input logic [63:0] rpc);
    st_t         n;
    longint      off;
    logic [63:0] tgt;
    n = s;
    if (brg) begin
      tgt = rtgt;
    end else if (ub) begin
      off = longint'($signed(a26));
      tgt = bpc + 64'(off * 4);
    end else begin
      off = longint'($signed(a19));
      tgt = bpc + 64'(off * 4);
    end
    if (!rst) begin
      n = '0;
      n.pc = rpc;
    end else if (stall) begin
      if (bt) begin
        n.pend = 1'b1;
        n.pt   = tgt;
      end
    end else begin
      n.ins  = imem(s.pc);
      n.ipc  = s.pc;
      n.ip4  = s.pc + 64'd4;
      n.v    = 1'b1;
      n.pend = 1'b0;
      if (bt)          n.pc = tgt;
      else if (s.pend) n.pc = s.pt;
      else             n.pc = s.pc + 64'd4;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs at the falling edge and record the expected result.
  task automatic tick(input logic r, input logic s, input logic t, input logic u,
                      input logic g, input logic [63:0] p, input logic [25:0] i26,
                      input logic [18:0] i19, input logic [63:0] rt);
    @(negedge clk);
    rst = r; stall = s; bt = t; ub = u; brg = g;
    bpc = p; a26 = i26; a19 = i19; rtgt = rt;
    m_lo = step(m_lo, 64'h0);
    m_hi = step(m_hi, HI_RESET_PC);
    exp_q.push_back('{lo: m_lo, hi: m_hi});
  endtask

  task automatic idle();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare every presented output set against the scoreboard.
  initial forever begin
    pair_t e;
    @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc", pc_lo, e.lo.pc);
      chk("if_id_instr", {32'h0, iins_lo}, {32'h0, e.lo.ins});
      chk("if_id_pc", ipc_lo, e.lo.ipc);
      chk("if_id_pc_plus4", ip4_lo, e.lo.ip4);
      chk("if_id_valid", {63'h0, v_lo}, {63'h0, e.lo.v});
      chk("redirect_pending", {63'h0, pend_lo}, {63'h0, e.lo.pend});
      chk("hi_pc", pc_hi, e.hi.pc);
      chk("hi_if_id_instr", {32'h0, iins_hi}, {32'h0, e.hi.ins});
      chk("hi_if_id_pc", ipc_hi, e.hi.ipc);
      chk("hi_if_id_valid", {63'h0, v_hi}, {63'h0, e.hi.v});
      chk("hi_redirect_pending", {63'h0, pend_hi}, {63'h0, e.hi.pend});
    end
  end

  initial begin
    logic        r, s, t, u, g;
    logic [63:0] p, rt;
    // Reset for two cycles, then sequential fetch.
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    settle();
    chk("reset_pc", pc_lo, 64'h0);
    chk("reset_valid", {63'h0, v_lo}, 64'h0);
    chk("hi_reset_pc", pc_hi, HI_RESET_PC);
    idle();
    settle();
    chk("first_valid", {63'h0, v_lo}, 64'h1);
    chk("first_pc", pc_lo, 64'h4);
    chk("hi_wrap_pc", pc_hi, 64'h0);
    repeat (4) idle();   // pc now 0x14
    // B with imm26 = -2 from br_pc 0x10; delay slot at 0x14 kept.
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h10, 26'h3FF_FFFE, '0, '0);
    settle();
    chk("b_target", pc_lo, 64'h08);
    chk("b_delay_slot", ipc_lo, 64'h14);
    // CBZ-style imm19 = 5 from 0x20, then BR to 0x100.
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h20, '0, 19'h5, '0);
    settle();
    chk("cond_target", pc_lo, 64'h34);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, '0, '0, '0, 64'h100);
    settle();
    chk("br_target", pc_lo, 64'h100);
    chk("br_slot_pc4", ip4_lo, 64'h38);
    // Stall with a buffered redirect.
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, '0, '0, '0, 64'h40);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, '0, '0, '0, 64'h80);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    settle();
    chk("stall_pc_hold", pc_lo, 64'h40);
    chk("stall_pending", {63'h0, pend_lo}, 64'h1);
    idle();
    settle();
    chk("pending_applied", pc_lo, 64'h80);
    chk("pending_cleared", {63'h0, pend_lo}, 64'h0);
    // Live branch beats buffered target.
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, '0, '0, '0, 64'h80);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, '0, '0, '0, 64'h200);
    settle();
    chk("live_beats_pending", pc_lo, 64'h200);
    // Reset discards a buffered redirect.
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, '0, '0, '0, 64'h300);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    settle();
    chk("reset_clears_pending", {63'h0, pend_lo}, 64'h0);
    chk("reset_pc_again", pc_lo, 64'h0);
    idle();
    settle();
    chk("no_stale_redirect", pc_lo, 64'h4);
    // Randomized phase.
    for (int i = 0; i < 2000; i++) begin
      r  = ($urandom_range(0, 63) != 0);
      s  = ($urandom_range(0, 2) == 0);
      t  = ($urandom_range(0, 3) == 0);
      u  = $urandom_range(0, 1) != 0;
      g  = ($urandom_range(0, 3) == 0);
      p  = {$urandom, $urandom};
      rt = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3) * 4)
                                       : {$urandom, $urandom};
      tick(r, s, t, u, g, p, 26'($urandom), 19'($urandom), rt);
    end
    idle();
    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage for the pipelined LEGv8 datapath.
- Owns the program counter and drives the instruction-memory address.
- Computes next-PC for sequential, B/BL, B.LT/CBZ and BR flow, and registers the fetched instruction into the IF/ID pipeline register consumed by the decode/control stage.
- Branches resolve in ID with one architectural delay slot, so there is no squash on redirect.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- ADDR_WIDTH, 64, PC/address width.
- INSTR_WIDTH, 32, instruction width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- stall  input  1  from hazard unit; holds PC and IF/ID.
- br_taken  input  1  from ID: redirect this cycle.
- uncond_br  input  1  from ID: 1 = use imm26 offset, 0 = use imm19 offset.
- br_reg  input  1  from ID: BR, target = reg_target; overrides uncond_br.
- br_pc  input  ADDR_WIDTH  PC of the branch instruction in ID.
- br_addr26  input  26  imm26 from the branch instruction.
- cond_addr19  input  19  imm19 from the branch instruction.
- reg_target  input  ADDR_WIDTH  Reg[Rd] for BR.
- instr_in  input  INSTR_WIDTH  instruction-memory read data for address pc (combinational read).
- pc  output  ADDR_WIDTH  current fetch address to instruction memory.
- if_id_instr  output  INSTR_WIDTH  registered instruction.
- if_id_pc  output  ADDR_WIDTH  registered PC of that instruction.
- if_id_pc_plus4  output  ADDR_WIDTH  registered PC+4 (BL link value).
- if_id_valid  output  1  registered valid; 0 = bubble.
- redirect_pending  output  1  a redirect is buffered during stall.

Behaviour:
- Reset (reset==0 at posedge):
  - pc=RESET_PC.
  - if_id_instr=0, if_id_pc=0, if_id_pc_plus4=0, if_id_valid=0, redirect_pending=0.
  - All inputs are ignored while reset is asserted.
  - Reset asserted mid-operation discards any buffered redirect.
- Target arithmetic, all modulo 2^64:
  - br_reg=1: target = reg_target.
  - uncond_br=1: target = br_pc + (sign_extend(br_addr26) << 2).
  - otherwise: target = br_pc + (sign_extend(cond_addr19) << 2).
  - Sequential: pc+4 wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0.
- Normal cycle (stall=0):
  - IF/ID <= {instr_in, pc, pc+4}; if_id_valid <= 1.
  - pc <= target if br_taken; else buffered target if redirect_pending; else pc+4.
  - redirect_pending <= 0.
- Delay slot: the instruction fetched in the same cycle that br_taken is high is captured into IF/ID and is always executed. There is no flush port.
- Stall cycle (stall=1):
  - pc and all IF/ID registers hold their values.
  - If br_taken=1, the computed target is latched into an internal pend_target register and redirect_pending <= 1.
  - A later br_taken during the same stall overwrites pend_target (last wins).
- Redirect priority when stall drops: a live br_taken beats the buffered target.
- First fetch: the first posedge after reset release latches instr_in at RESET_PC with if_id_valid=1. Outputs in the reset cycle itself are the reset values.
- Latency: instruction at address A appears on if_id_instr one cycle after pc==A. A redirect asserted in cycle N puts the target on pc in cycle N+1, provided there is no stall.
- No handshake with instruction memory: single-cycle combinational read.

Test Plan:
1. Reset low 2 cycles, RESET_PC=0, then release; imem holds word k at 4k -> pc sequence 0,4,8,12; if_id_pc lags pc by 1 cycle; if_id_valid=0 during reset, 1 from the first edge after release.
2. br_taken=1, uncond_br=1, br_pc=0x10, br_addr26=26'h3FFFFFE (−2) while pc=0x14 -> if_id_pc=0x14 (delay slot kept), next pc=0x08.
3. br_taken=1, uncond_br=0, br_reg=0, br_pc=0x20, cond_addr19=19'h5 -> next pc=0x34; then br_reg=1, reg_target=0x100 -> next pc=0x100, if_id_pc_plus4 of the delay slot = that slot's PC+4.
4. stall=1 for 3 cycles at pc=0x40, br_taken pulse in the 2nd stall cycle (target 0x80) -> pc and IF/ID frozen, redirect_pending=1; after stall drops pc=0x80, redirect_pending=0.
5. Buffered target 0x80 pending, stall drops with live br_taken to 0x200 -> pc=0x200.
6. pc forced by reset to RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> next pc=0 (wrap). Reset asserted while redirect_pending=1 -> pending cleared, pc=RESET_PC.
